// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce, key code output.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_deb
    $error("DEBOUNCE_TICKS must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div;
  logic            tick;
  logic [3:0]      row_meta, row_sync;
  logic [3:0]      cap, cap_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      col_nx, code_nx;
  logic            valid_nx, held_nx;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!v[i]) low_idx = 2'(i);
  endfunction

  // rows come from an external pulled-up matrix, so resync before use
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  assign tick = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || tick) div <= '0;
    else                 div <= div + 1'b1;
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt, rpt_nx;
  logic          rpt_arm, arm_nx;
  logic          rpt_fire;

  // first period is REPEAT_DELAY, every later one REPEAT_RATE
  assign rpt_fire = (!rpt_arm && rpt == RW'(REPEAT_DELAY - 1)) ||
                    ( rpt_arm && rpt == RW'(REPEAT_RATE - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rpt     <= '0;
      rpt_arm <= 1'b0;
    end else begin
      rpt     <= rpt_nx;
      rpt_arm <= arm_nx;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= SCAN;
      key_col   <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cnt       <= '0;
      cap       <= 4'hF;
    end else begin
      state     <= state_nx;
      key_col   <= col_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
      cnt       <= cnt_nx;
      cap       <= cap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = key_col;
    code_nx  = key_code;
    valid_nx = 1'b0;
    held_nx  = key_held;
    cnt_nx   = cnt;
    cap_nx   = cap;
`ifdef KEY_REPEAT_EN
    rpt_nx   = rpt;
    arm_nx   = rpt_arm;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if ($onehot(~row_sync)) begin
            cap_nx   = row_sync;
            cnt_nx   = '0;
            state_nx = DEBOUNCE;
          end else begin
            col_nx = {key_col[2:0], key_col[3]};
          end
        end
        DEBOUNCE: begin
          if (row_sync == cap) begin
            if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
              state_nx = PRESSED;
              code_nx  = {low_idx(cap), low_idx(key_col)};
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              cnt_nx   = '0;
`ifdef KEY_REPEAT_EN
              rpt_nx   = '0;
              arm_nx   = 1'b0;
`endif
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            // column stays put; the next SCAN tick moves on
            state_nx = SCAN;
          end
        end
        PRESSED: begin
          if (row_sync == 4'hF) begin
            cnt_nx   = '0;
            state_nx = RELEASE;
          end else begin
`ifdef KEY_REPEAT_EN
            if (rpt_fire) begin
              valid_nx = 1'b1;
              rpt_nx   = '0;
              arm_nx   = 1'b1;
            end else begin
              rpt_nx = rpt + 1'b1;
            end
`endif
          end
        end
        RELEASE: begin
          if (row_sync == 4'hF) begin
            if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
              held_nx  = 1'b0;
              col_nx   = {key_col[2:0], key_col[3]};
              cnt_nx   = '0;
              state_nx = SCAN;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            // bounce during release: back to held, repeat count resumes
            state_nx = PRESSED;
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

endmodule
